// File: rtl/ga_pkg.sv
// Definitions shared between ga and its result logger: gene/fitness widths,
// their types, and the logger FSM encoding. Log word width depends on GA_LOG_FIT_EN.
package ga_pkg;

  localparam int CHROM_W = 8;
  localparam int FIT_W   = 27;

  typedef logic [CHROM_W-1:0] chrom_t;
  typedef logic [FIT_W-1:0]   fit_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOG  = 2'd1,
    S_DONE = 2'd2
  } log_state_t;

  // Log word layout is {chromosome, fitness}; fitness is only stored when enabled.
`ifdef GA_LOG_FIT_EN
  localparam int LOG_W = CHROM_W + FIT_W;
`else
  localparam int LOG_W = CHROM_W;
`endif

endpackage

// File: rtl/ga_log_mem.sv
// Generation log storage: DEPTH x W synchronous RAM with one write and one read
// address, registered read-first output that holds between reads.
module ga_log_mem
  import ga_pkg::*;
#(
  parameter int DEPTH = 100,
  parameter int AW    = 7,
  parameter int W     = LOG_W
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] wr_addr,
  input  logic [W-1:0]  wr_data,
  input  logic          re,
  input  logic          rd_zero,
  input  logic [AW-1:0] rd_addr,
  output logic [W-1:0]  rd_data
);

  logic [W-1:0] mem_q [DEPTH];
  logic [W-1:0] rd_data_q;

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  // Read samples the array before this edge's write lands (read-first).
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data_q <= '0;
    end else if (re) begin
      rd_data_q <= rd_zero ? '0 : mem_q[rd_addr];
    end
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/ga_best_log.sv
// Per-generation result logger behind ga: buffers best/best_fit, tracks the all-time
// best and stall count, and serves a 1-cycle read port. Fitness storage: GA_LOG_FIT_EN.
module ga_best_log
  import ga_pkg::*;
#(
  parameter int  GENS        = 100,
  parameter int  STALL_LIMIT = 10,
  localparam int AW          = (GENS > 1) ? $clog2(GENS) : 1,
  localparam int CW          = $clog2(GENS + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          gen_valid,
  input  chrom_t        best,
  input  fit_t          best_fit,
  input  logic          finished,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output logic          rd_valid,
  output chrom_t        rd_best,
  output fit_t          rd_fit,
  output logic [CW-1:0] gen_count,
  output chrom_t        top_best,
  output fit_t          top_fit,
  output logic [AW-1:0] top_gen,
  output logic [CW-1:0] stall,
  output logic          converged,
  output logic          done,
  output logic          overflow
);

  log_state_t    state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  chrom_t        top_best_q, top_best_d;
  fit_t          top_fit_q, top_fit_d;
  logic [AW-1:0] top_gen_q, top_gen_d;
  logic [CW-1:0] stall_q, stall_d;
  logic          ovf_q, ovf_d;
  logic          rd_valid_q;

  logic          we;
  logic [AW-1:0] wr_addr;
  logic [LOG_W-1:0] wr_data;
  logic [LOG_W-1:0] rd_data;
  logic          rd_zero;

  assign wr_addr = count_q[AW-1:0];
  // Unwritten slots (including the one being written this cycle) read as zero.
  assign rd_zero = CW'(rd_addr) >= count_q;

`ifdef GA_LOG_FIT_EN
  assign wr_data = {best, best_fit};
  assign rd_best = rd_data[LOG_W-1:FIT_W];
  assign rd_fit  = rd_data[FIT_W-1:0];
`else
  assign wr_data = best;
  assign rd_best = rd_data;
  assign rd_fit  = '0;
`endif

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    top_best_d = top_best_q;
    top_fit_d  = top_fit_q;
    top_gen_d  = top_gen_q;
    stall_d    = stall_q;
    ovf_d      = ovf_q;
    we         = 1'b0;
    unique case (state_q)
      S_IDLE, S_LOG: begin
        if (gen_valid) begin
          we      = 1'b1;
          count_d = count_q + 1'b1;
          state_d = S_LOG;
          // The first entry seeds the record regardless of its fitness.
          if ((state_q == S_IDLE) || (best_fit > top_fit_q)) begin
            top_best_d = best;
            top_fit_d  = best_fit;
            top_gen_d  = wr_addr;
            stall_d    = '0;
          end else if (stall_q != CW'(GENS)) begin
            stall_d = stall_q + 1'b1;
          end
        end
        if (finished || (count_d == CW'(GENS))) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (gen_valid) begin
          ovf_d = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      count_q    <= '0;
      top_best_q <= '0;
      top_fit_q  <= '0;
      top_gen_q  <= '0;
      stall_q    <= '0;
      ovf_q      <= 1'b0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      top_best_q <= top_best_d;
      top_fit_q  <= top_fit_d;
      top_gen_q  <= top_gen_d;
      stall_q    <= stall_d;
      ovf_q      <= ovf_d;
      rd_valid_q <= rd_en;
    end
  end

  ga_log_mem #(
    .DEPTH (GENS),
    .AW    (AW),
    .W     (LOG_W)
  ) u_mem (
    .clk     (clk),
    .rst     (reset),
    .we      (we && !reset),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .re      (rd_en),
    .rd_zero (rd_zero),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  assign rd_valid  = rd_valid_q;
  assign gen_count = count_q;
  assign top_best  = top_best_q;
  assign top_fit   = top_fit_q;
  assign top_gen   = top_gen_q;
  assign stall     = stall_q;
  assign converged = stall_q >= CW'(STALL_LIMIT);
  assign done      = (state_q == S_DONE);
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_ga_best_log.sv
// Directed bench for ga_best_log: a full-size instance and a 4-deep instance,
// with a queue scoreboard for the read port.
module tb_ga_best_log;
  import ga_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        gv_a, fin_a, rd_en_a;
  logic        gv_c, fin_c, rd_en_c;
  logic [7:0]  best;
  logic [26:0] fit;
  logic [6:0]  rd_addr_a;
  logic [1:0]  rd_addr_c;

  logic        a_rd_valid, a_converged, a_done, a_overflow;
  logic [7:0]  a_rd_best, a_top_best;
  logic [26:0] a_rd_fit, a_top_fit;
  logic [6:0]  a_gen_count, a_top_gen, a_stall;

  logic        c_rd_valid, c_converged, c_done, c_overflow;
  logic [7:0]  c_rd_best, c_top_best;
  logic [26:0] c_rd_fit, c_top_fit;
  logic [2:0]  c_gen_count, c_stall;
  logic [1:0]  c_top_gen;

  ga_best_log #(.GENS(100), .STALL_LIMIT(10)) dut_a (
    .clk(clk), .reset(rst), .gen_valid(gv_a), .best(best), .best_fit(fit),
    .finished(fin_a), .rd_en(rd_en_a), .rd_addr(rd_addr_a),
    .rd_valid(a_rd_valid), .rd_best(a_rd_best), .rd_fit(a_rd_fit),
    .gen_count(a_gen_count), .top_best(a_top_best), .top_fit(a_top_fit),
    .top_gen(a_top_gen), .stall(a_stall), .converged(a_converged),
    .done(a_done), .overflow(a_overflow)
  );

  ga_best_log #(.GENS(4), .STALL_LIMIT(2)) dut_c (
    .clk(clk), .reset(rst), .gen_valid(gv_c), .best(best), .best_fit(fit),
    .finished(fin_c), .rd_en(rd_en_c), .rd_addr(rd_addr_c),
    .rd_valid(c_rd_valid), .rd_best(c_rd_best), .rd_fit(c_rd_fit),
    .gen_count(c_gen_count), .top_best(c_top_best), .top_fit(c_top_fit),
    .top_gen(c_top_gen), .stall(c_stall), .converged(c_converged),
    .done(c_done), .overflow(c_overflow)
  );

  typedef struct {
    int          due;
    logic [7:0]  b;
    logic [26:0] f;
  } exp_t;

  exp_t q_a[$];
  exp_t q_c[$];
  exp_t ea, ec;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_pass = 0;
  int   n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [26:0] efit(input logic [26:0] f);
`ifdef GA_LOG_FIT_EN
    return f;
`else
    return 27'd0;
`endif
  endfunction

  // Read scoreboard: each queued read must surface exactly on its due cycle.
  always @(negedge clk) begin
    if (q_a.size() != 0 && q_a[0].due == cyc) begin
      ea = q_a.pop_front();
      chk("a_rd_valid", a_rd_valid, 1'b1);
      chk("a_rd_best", a_rd_best, ea.b);
      chk("a_rd_fit", a_rd_fit, ea.f);
    end else begin
      chk("a_rd_idle", a_rd_valid, 1'b0);
    end
  end

  always @(negedge clk) begin
    if (q_c.size() != 0 && q_c[0].due == cyc) begin
      ec = q_c.pop_front();
      chk("c_rd_valid", c_rd_valid, 1'b1);
      chk("c_rd_best", c_rd_best, ec.b);
      chk("c_rd_fit", c_rd_fit, ec.f);
    end else begin
      chk("c_rd_idle", c_rd_valid, 1'b0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic log_a(input logic [7:0] b, input logic [26:0] f, input logic fin);
    best = b; fit = f; gv_a = 1'b1; fin_a = fin;
    tick();
    gv_a = 1'b0; fin_a = 1'b0;
  endtask

  task automatic read_a(input int addr, input logic [7:0] b, input logic [26:0] f);
    exp_t e;
    e.due = cyc + 1; e.b = b; e.f = efit(f);
    q_a.push_back(e);
    rd_en_a = 1'b1; rd_addr_a = 7'(addr);
    tick();
    rd_en_a = 1'b0;
  endtask

  task automatic read_c(input int addr, input logic [7:0] b, input logic [26:0] f);
    exp_t e;
    e.due = cyc + 1; e.b = b; e.f = efit(f);
    q_c.push_back(e);
    rd_en_c = 1'b1; rd_addr_c = 2'(addr);
    tick();
    rd_en_c = 1'b0;
  endtask

  initial begin
    exp_t e;
    rst = 1'b1;
    gv_a = 0; fin_a = 0; rd_en_a = 0; rd_addr_a = '0;
    gv_c = 0; fin_c = 0; rd_en_c = 0; rd_addr_c = '0;
    best = '0; fit = '0;

    // Reset held for two edges while inputs toggle
    for (int i = 0; i < 2; i++) begin
      gv_a = 1'($urandom); fin_a = 1'($urandom); rd_en_a = 1'($urandom);
      gv_c = 1'($urandom); fin_c = 1'($urandom); rd_en_c = 1'($urandom);
      rd_addr_a = 7'($urandom); rd_addr_c = 2'($urandom);
      best = 8'($urandom); fit = 27'($urandom);
      tick();
    end
    rst = 0; gv_a = 0; fin_a = 0; rd_en_a = 0; gv_c = 0; fin_c = 0; rd_en_c = 0;
    chk("rst_gen_count", a_gen_count, 0);
    chk("rst_top_best", a_top_best, 0);
    chk("rst_top_fit", a_top_fit, 0);
    chk("rst_top_gen", a_top_gen, 0);
    chk("rst_stall", a_stall, 0);
    chk("rst_converged", a_converged, 0);
    chk("rst_done", a_done, 0);
    chk("rst_overflow", a_overflow, 0);
    chk("rst_rd_best", a_rd_best, 0);
    chk("rst_rd_fit", a_rd_fit, 0);
    chk("rst_c_gen_count", c_gen_count, 0);
    chk("rst_c_done", c_done, 0);

    // Top tracking
    log_a(8'h10, 27'd100, 1'b0);
    chk("tt1_top_best", a_top_best, 8'h10);
    chk("tt1_top_fit", a_top_fit, 100);
    chk("tt1_stall", a_stall, 0);
    chk("tt1_gen_count", a_gen_count, 1);
    log_a(8'h20, 27'd250, 1'b0);
    chk("tt2_top_gen", a_top_gen, 1);
    // Third entry written while the same address is read: read-first zeros
    e.due = cyc + 1; e.b = 8'h00; e.f = 27'd0;
    q_a.push_back(e);
    best = 8'h30; fit = 27'd250; gv_a = 1'b1; rd_en_a = 1'b1; rd_addr_a = 7'd2;
    tick();
    gv_a = 1'b0; rd_en_a = 1'b0;
    chk("tt3_top_best", a_top_best, 8'h20);
    chk("tt3_top_fit", a_top_fit, 250);
    chk("tt3_top_gen", a_top_gen, 1);
    chk("tt3_stall", a_stall, 1);
    chk("tt3_gen_count", a_gen_count, 3);
    chk("tt3_done", a_done, 0);
    read_a(1, 8'h20, 27'd250);
    read_a(2, 8'h30, 27'd250);
    tick();

    // Convergence
    do_reset();
    chk("cv_gen_count_rst", a_gen_count, 0);
    log_a(8'h05, 27'd500, 1'b0);
    for (int i = 0; i < 10; i++) begin
      log_a(8'(8'h40 + i), 27'd400, 1'b0);
      chk("cv_stall", a_stall, 7'(i + 1));
      chk("cv_converged", a_converged, (i == 9));
    end
    chk("cv_top_best", a_top_best, 8'h05);
    chk("cv_top_gen", a_top_gen, 0);
    log_a(8'h66, 27'd600, 1'b0);
    chk("cv_improve_stall", a_stall, 0);
    chk("cv_improve_conv", a_converged, 0);
    chk("cv_improve_gen", a_top_gen, 11);

    // Early finish and readback
    do_reset();
    log_a(8'h11, 27'd111, 1'b0);
    log_a(8'h22, 27'd222, 1'b0);
    chk("ef_done_early", a_done, 0);
    log_a(8'h33, 27'd333, 1'b1);
    chk("ef_gen_count", a_gen_count, 3);
    chk("ef_done", a_done, 1);
    chk("ef_top_gen", a_top_gen, 2);
    read_a(3, 8'h00, 27'd0);
    read_a(0, 8'h11, 27'd111);
    read_a(1, 8'h22, 27'd222);
    read_a(2, 8'h33, 27'd333);
    tick();
    tick();
    chk("ef_hold_best", a_rd_best, 8'h33);
    chk("ef_hold_fit", a_rd_fit, efit(27'd333));
    log_a(8'h44, 27'd444, 1'b0);
    chk("ef_overflow", a_overflow, 1);
    chk("ef_count_frozen", a_gen_count, 3);
    read_a(3, 8'h00, 27'd0);
    tick();

    // Reset mid-LOG with a read in flight
    do_reset();
    log_a(8'h71, 27'd71, 1'b0);
    log_a(8'h72, 27'd72, 1'b0);
    rst = 1'b1; rd_en_a = 1'b1; rd_addr_a = 7'd0;
    tick();
    rst = 1'b0; rd_en_a = 1'b0;
    chk("rm_gen_count", a_gen_count, 0);
    chk("rm_top_best", a_top_best, 0);
    chk("rm_rd_valid", a_rd_valid, 0);
    chk("rm_done", a_done, 0);
    read_a(0, 8'h00, 27'd0);
    tick();

    // Capacity on the 4-deep instance
    do_reset();
    for (int i = 0; i < 5; i++) begin
      best = 8'(8'h50 + i); fit = 27'(10 * (i + 1)); gv_c = 1'b1;
      tick();
      gv_c = 1'b0;
      chk("cap_done", c_done, (i >= 3));
      chk("cap_overflow", c_overflow, (i == 4));
      chk("cap_gen_count", c_gen_count, (i < 4) ? 3'(i + 1) : 3'd4);
    end
    chk("cap_top_best", c_top_best, 8'h53);
    chk("cap_top_gen", c_top_gen, 3);
    read_c(3, 8'h53, 27'd40);
    read_c(0, 8'h50, 27'd10);
    tick();

    // Finish in IDLE with nothing logged
    do_reset();
    fin_c = 1'b1;
    tick();
    fin_c = 1'b0;
    chk("fi_done", c_done, 1);
    chk("fi_gen_count", c_gen_count, 0);
    chk("fi_top_fit", c_top_fit, 0);
    best = 8'h99; fit = 27'd999; gv_c = 1'b1;
    tick();
    gv_c = 1'b0;
    chk("fi_overflow", c_overflow, 1);
    chk("fi_count_frozen", c_gen_count, 0);
    chk("fi_top_best", c_top_best, 0);

    tick();
    tick();
    tick();
    chk("sb_a_empty", q_a.size(), 0);
    chk("sb_c_empty", q_c.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
